// File: rtl/stateful_action_exec.sv
// stateful_action_exec: buffers action-tagged 512-bit packet beats in a FIFO,
// executes NOP/FWD/DROP/STAMP on pop and drives egress through a valid/ready
// output register, with saturating forward/drop/overflow counters.
// Optional feature macro: STATE_STAMP_EN (STAMP writes the stored flow state
// into byte STAMP_BYTE; when undefined, STAMP behaves like FWD).
module stateful_action_exec #(
  parameter int unsigned DEPTH_BITS   = 4,
  parameter logic [7:0]  DEFAULT_PORT = 8'h00,
  parameter int unsigned STAMP_BYTE   = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pkt_vld_in,
  input  logic [511:0] pkt_data_in,
  input  logic [15:0]  action_in,
  input  logic [7:0]   state_in,
  output logic         in_ready,
  output logic         pkt_vld_out,
  output logic [511:0] pkt_data_out,
  output logic [7:0]   port_out,
  input  logic         pkt_rdy_out,
  output logic [31:0]  fwd_cnt,
  output logic [31:0]  drop_cnt,
  output logic [31:0]  ovf_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam int unsigned DW    = 512;
  localparam int unsigned EW    = DW + 24;
  localparam logic [DEPTH_BITS:0] FULL_CNT  = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [8:0]          STAMP_LSB = 9'(STAMP_BYTE * 8);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_FWD   = 8'h01;
  localparam logic [7:0] OP_STAMP = 8'h03;

`ifdef STATE_STAMP_EN
  localparam bit STAMP_STATE = 1'b1;
`else
  localparam bit STAMP_STATE = 1'b0;
`endif

  // FIFO entry layout: {state[535:528], opcode[527:520], arg[519:512], data[511:0]}
  logic [EW-1:0]         r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;

  logic                  r_vld_out;
  logic [DW-1:0]         r_data_out;
  logic [7:0]            r_port_out;
  logic [31:0]           r_fwd_cnt;
  logic [31:0]           r_drop_cnt;
  logic [31:0]           r_ovf_cnt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_hs;
  logic                  w_ovf;
  logic [7:0]            w_state;
  logic [7:0]            w_op;
  logic [7:0]            w_arg;
  logic [DW-1:0]         w_data;
  logic [DW-1:0]         w_stamped;
  logic [DW-1:0]         w_nxt_data;
  logic [7:0]            w_nxt_port;
  logic                  w_drop;

  assign in_ready = (r_count < FULL_CNT);
  assign w_push   = pkt_vld_in && in_ready;
  assign w_ovf    = pkt_vld_in && !in_ready;
  assign w_pop    = (r_count != '0) && (!r_vld_out || pkt_rdy_out);
  assign w_hs     = r_vld_out && pkt_rdy_out;

  assign w_state  = r_mem[r_rd_ptr][535:528];
  assign w_op     = r_mem[r_rd_ptr][527:520];
  assign w_arg    = r_mem[r_rd_ptr][519:512];
  assign w_data   = r_mem[r_rd_ptr][511:0];

  // Decode the head entry's action into the next output beat or a drop
  always_comb begin
    w_nxt_data = w_data;
    w_nxt_port = DEFAULT_PORT;
    w_drop     = 1'b0;
    w_stamped  = w_data;
    w_stamped[STAMP_LSB +: 8] = w_state;
    case (w_op)
      OP_NOP:   w_nxt_port = DEFAULT_PORT;
      OP_FWD:   w_nxt_port = w_arg;
      OP_STAMP: begin
        w_nxt_port = w_arg;
        if (STAMP_STATE) w_nxt_data = w_stamped;
      end
      default:  w_drop = 1'b1;
    endcase
  end

  // FIFO storage write (contents are don't-care until pushed)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {state_in, action_in, pkt_data_in};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_BITS+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: load on non-drop pop, clear after handshake otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_out  <= 1'b0;
      r_data_out <= '0;
      r_port_out <= '0;
    end else if (w_pop && !w_drop) begin
      r_vld_out  <= 1'b1;
      r_data_out <= w_nxt_data;
      r_port_out <= w_nxt_port;
    end else if (w_hs) begin
      r_vld_out  <= 1'b0;
    end
  end

  // Saturating statistics, one increment per counter per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      if (w_hs && (r_fwd_cnt != '1))            r_fwd_cnt  <= r_fwd_cnt + 32'd1;
      if (w_pop && w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_ovf && (r_ovf_cnt != '1))           r_ovf_cnt  <= r_ovf_cnt + 32'd1;
    end
  end

  assign pkt_vld_out  = r_vld_out;
  assign pkt_data_out = r_data_out;
  assign port_out     = r_port_out;
  assign fwd_cnt      = r_fwd_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign ovf_cnt      = r_ovf_cnt;

endmodule

// File: tb/tb_stateful_action_exec.sv
// tb_stateful_action_exec: directed test of stateful_action_exec with
// hand-computed expectations (default parameters, DEPTH = 16).
module tb_stateful_action_exec;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pkt_vld_in = 1'b0;
  logic [511:0] pkt_data_in = '0;
  logic [15:0]  action_in = '0;
  logic [7:0]   state_in = '0;
  logic         in_ready;
  logic         pkt_vld_out;
  logic [511:0] pkt_data_out;
  logic [7:0]   port_out;
  logic         pkt_rdy_out = 1'b0;
  logic [31:0]  fwd_cnt;
  logic [31:0]  drop_cnt;
  logic [31:0]  ovf_cnt;

  int n_total = 0;
  int n_bad   = 0;

  int           k4;
  int           p5;
  int           k5;
  bit           acc5;
  bit           stalled5;
  logic [511:0] held5;
  logic         seen;
  logic [511:0] d5;
  logic [511:0] e5;

  stateful_action_exec dut (
    .clk          (clk),
    .reset        (reset),
    .pkt_vld_in   (pkt_vld_in),
    .pkt_data_in  (pkt_data_in),
    .action_in    (action_in),
    .state_in     (state_in),
    .in_ready     (in_ready),
    .pkt_vld_out  (pkt_vld_out),
    .pkt_data_out (pkt_data_out),
    .port_out     (port_out),
    .pkt_rdy_out  (pkt_rdy_out),
    .fwd_cnt      (fwd_cnt),
    .drop_cnt     (drop_cnt),
    .ovf_cnt      (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk(input int s);
    logic [511:0] d;
    for (int j = 0; j < 16; j++) d[j*32 +: 32] = 32'(s*16 + j) ^ 32'h5A00_0000;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [511:0] d, input logic [15:0] act, input logic [7:0] st);
    pkt_vld_in  = 1'b1;
    pkt_data_in = d;
    action_in   = act;
    state_in    = st;
  endtask

  task automatic wait_vld(input int maxc);
    for (int c = 0; c < maxc && !pkt_vld_out; c++) step();
    chk("wait_vld", 512'(pkt_vld_out), 512'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", 512'(in_ready), 512'd1);
    chk("rst_vld",      512'(pkt_vld_out), 512'd0);
    chk("rst_data",     pkt_data_out, 512'd0);
    chk("rst_port",     512'(port_out), 512'd0);
    chk("rst_fwd",      512'(fwd_cnt), 512'd0);
    chk("rst_drop",     512'(drop_cnt), 512'd0);
    chk("rst_ovf",      512'(ovf_cnt), 512'd0);

    // test 1: FWD to port 5, latency N+2
    pkt_rdy_out = 1'b1;
    drive(mk(1), 16'h0105, 8'h00);
    step();
    pkt_vld_in = 1'b0;
    chk("t1_vld_n1", 512'(pkt_vld_out), 512'd0);
    step();
    chk("t1_vld_n2", 512'(pkt_vld_out), 512'd1);
    chk("t1_port",   512'(port_out), 512'd5);
    chk("t1_data",   pkt_data_out, mk(1));
    step();
    chk("t1_fwd",    512'(fwd_cnt), 512'd1);
    chk("t1_vld_off", 512'(pkt_vld_out), 512'd0);

    // test 2: DROP then NOP; unknown opcode dropped
    drive(mk(2), 16'h0200, 8'h00);
    step();
    drive(mk(3), 16'h0000, 8'h00);
    step();
    pkt_vld_in = 1'b0;
    wait_vld(8);
    chk("t2_data", pkt_data_out, mk(3));
    chk("t2_port", 512'(port_out), 512'h00);
    chk("t2_drop1", 512'(drop_cnt), 512'd1);
    step();
    drive(mk(4), 16'h7F00, 8'h00);
    step();
    pkt_vld_in = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      seen = seen | pkt_vld_out;
      step();
    end
    chk("t2_not_shown", 512'(seen), 512'd0);
    chk("t2_drop2", 512'(drop_cnt), 512'd2);
    chk("t2_fwd",   512'(fwd_cnt), 512'd2);

    // test 3: STAMP with state A5 into byte 0
    d5 = mk(5);
    d5[7:0] = 8'h3C;
    e5 = d5;
`ifdef STATE_STAMP_EN
    e5[7:0] = 8'hA5;
`endif
    drive(d5, 16'h0303, 8'hA5);
    step();
    pkt_vld_in = 1'b0;
    wait_vld(8);
    chk("t3_data", pkt_data_out, e5);
    chk("t3_port", 512'(port_out), 512'd3);
    step();
    chk("t3_fwd", 512'(fwd_cnt), 512'd3);

    // test 4: fill with egress stalled, overflow, then drain in order
    pkt_rdy_out = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(mk(100 + i), {8'h01, 8'(i)}, 8'h00);
      chk($sformatf("t4_in_ready_%0d", i), 512'(in_ready), 512'(i <= DEPTH));
      step();
    end
    pkt_vld_in = 1'b0;
    chk("t4_ovf", 512'(ovf_cnt), 512'd3);
    chk("t4_vld_held", 512'(pkt_vld_out), 512'd1);
    chk("t4_head", pkt_data_out, mk(100));
    step();
    chk("t4_head_stable", pkt_data_out, mk(100));
    pkt_rdy_out = 1'b1;
    k4 = 0;
    for (int c = 0; c < 60 && k4 < DEPTH + 1; c++) begin
      if (pkt_vld_out) begin
        chk($sformatf("t4_order_%0d", k4), pkt_data_out, mk(100 + k4));
        chk($sformatf("t4_port_%0d", k4), 512'(port_out), 512'(k4));
        k4++;
      end
      step();
    end
    chk("t4_drained", 512'(k4), 512'(DEPTH + 1));
    step();
    chk("t4_fwd", 512'(fwd_cnt), 512'd20);
    chk("t4_vld_off", 512'(pkt_vld_out), 512'd0);
    chk("t4_ovf_final", 512'(ovf_cnt), 512'd3);

    // test 6: reset with beats queued
    pkt_rdy_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(300 + i), 16'h0101, 8'h00);
      step();
    end
    pkt_vld_in = 1'b0;
    step();
    chk("t6_vld_pre", 512'(pkt_vld_out), 512'd1);
    reset = 1'b1;
    step();
    chk("t6_vld",      512'(pkt_vld_out), 512'd0);
    chk("t6_in_ready", 512'(in_ready), 512'd1);
    chk("t6_data",     pkt_data_out, 512'd0);
    chk("t6_fwd",      512'(fwd_cnt), 512'd0);
    chk("t6_drop",     512'(drop_cnt), 512'd0);
    chk("t6_ovf",      512'(ovf_cnt), 512'd0);
    reset = 1'b0;
    pkt_rdy_out = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      step();
      seen = seen | pkt_vld_out;
    end
    chk("t6_flushed", 512'(seen), 512'd0);

    // test 5: 20 FWD beats with egress ready toggling 1010..
    p5 = 0;
    k5 = 0;
    stalled5 = 1'b0;
    held5 = '0;
    fork
      begin
        for (int c = 0; c < 400 && p5 < 20; c++) begin
          drive(mk(200 + p5), {8'h01, 8'(p5)}, 8'h00);
          acc5 = in_ready;
          step();
          if (acc5) p5++;
        end
        pkt_vld_in = 1'b0;
      end
      begin
        for (int c = 0; c < 400 && k5 < 20; c++) begin
          if (stalled5) chk("t5_stable", pkt_data_out, held5);
          pkt_rdy_out = (c % 2 == 0);
          stalled5 = pkt_vld_out && !pkt_rdy_out;
          held5 = pkt_data_out;
          if (pkt_vld_out && pkt_rdy_out) begin
            chk($sformatf("t5_order_%0d", k5), pkt_data_out, mk(200 + k5));
            k5++;
          end
          step();
        end
      end
    join
    chk("t5_sent", 512'(p5), 512'd20);
    chk("t5_recv", 512'(k5), 512'd20);
    pkt_rdy_out = 1'b1;
    step();
    chk("t5_fwd",  512'(fwd_cnt), 512'd20);
    chk("t5_drop", 512'(drop_cnt), 512'd0);
    chk("t5_ovf",  512'(ovf_cnt), 512'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
